dassign1_code_gen: RTL and testbench
====================================

Name: dassign1_code_gen

Overview:
- Stimulus transmitter for the 4-bit code classifier: on command, emits a stream of 4-bit codes over a valid/ready handshake.
- Each code carries its expected classifier output.
- Accepted set (classifier y=1): 3, 6, 7, 9, 10, 11. Rejected set: all other 4-bit values.
- Sits upstream of the classifier on the test/datapath side; the downstream checker compares classifier y against code_exp.

Parameters:
- CNT_W, 5, width of the requested-length field (max 2^CNT_W-1 codes per run).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle run request; sampled only in IDLE.
- mode  input  2  set select: 00 accepted set, 01 rejected set, 10 all 16 codes ascending, 11 treated as 10.
- count  input  CNT_W  codes to emit; 0 means exactly one full pass of the selected set.
- busy  output  1  run in progress.
- code_valid  output  1  code/code_exp/code_last are valid.
- code_ready  input  1  downstream accepts the current code.
- code  output  4  emitted code.
- code_exp  output  1  expected classifier output for code.
- code_last  output  1  marks the final code of the run.
- done  output  1  one-cycle pulse after the final handshake.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low; no other reset.
- Reset values: busy=0, code_valid=0, code=0, code_exp=0, code_last=0, done=0, state=IDLE, index=0, remaining=0.
- Sets are stored in ascending order:
  - Accepted: 3, 6, 7, 9, 10, 11 (length 6).
  - Rejected: 0, 1, 2, 4, 5, 8, 12, 13, 14, 15 (length 10).
  - All: 0..15 (length 16).
- code_exp=1 iff code is in the accepted set, in every mode.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches mode and the effective length (count, or the set length if count=0), sets index=0, and goes to RUN.
  - In the next cycle, busy=1 and code_valid=1 presenting the first set element.
- RUN:
  - A handshake (code_valid & code_ready) advances to the next element.
  - index wraps to 0 after the last set element.
  - remaining decrements on each handshake.
  - With no handshake, code/code_exp/code_last hold stable and code_valid stays 1. Withdrawal is not allowed.
  - code_last=1 while remaining==1.
  - A handshake with code_last=1 goes to DONE; code_valid drops the following cycle.
  - Back-to-back handshakes with code_ready held high give one code per cycle.
- DONE (exactly one cycle): done=1, busy=0, code_valid=0, then IDLE.
  - start is ignored in DONE; the earliest accepted new start is the cycle after done.
- start while busy=1 or in DONE is ignored. A running run is not affected.
- mode and count changes outside an accepted start have no effect.
- Asynchronous reset mid-run returns all outputs to reset values immediately. No done pulse is produced.
- Effective length 1: first code has code_last=1.
- count greater than the set length wraps the set as many times as needed.

Decomposition:
- Shared package/header holds:
  - mode encodings (MODE_ACC=2'b00, MODE_REJ=2'b01, MODE_ALL=2'b10)
  - set lengths (LEN_ACC=6, LEN_REJ=10, LEN_ALL=16)
  - state encodings (IDLE, RUN, DONE)
- One sub-module, dassign1_code_rom: combinational (mode, index) -> (code, code_exp, set_len). The top keeps the FSM, index/remaining counters and handshake.

Test Plan:
- Accepted set, single pass: reset, then start with mode=00, count=0, code_ready=1.
  - Expect codes 3, 6, 7, 9, 10, 11 on consecutive cycles, all with code_exp=1.
  - Expect code_last only on 11, done one cycle later, and busy=0 in the done cycle.
- Rejected set, single pass: mode=01, count=0, code_ready=1.
  - Expect 0, 1, 2, 4, 5, 8, 12, 13, 14, 15, all with code_exp=0.
- Full sweep with wrap: mode=10, count=18.
  - Expect 0..15, then 0, 1, with code_last on the second 1.
  - Expect code_exp=1 exactly at 3, 6, 7, 9, 10, 11.
- Backpressure: mode=00, count=3, code_ready low for 4 cycles after the first valid, then toggled.
  - code holds at 3 while stalled.
  - Stream is 3, 6, 7 with no skips or duplicates; done after the handshake on 7.
- Ignored starts: start pulsed during RUN and during the DONE cycle with a different mode/count.
  - The current run is unchanged and no new run begins.
  - A start one cycle after done begins a new run.
- Mid-run reset: rst_n low asynchronously after the 2nd code.
  - All outputs go to 0 without waiting for a clock edge, with no done pulse.
  - After release, a new start begins again from the first element.

Source files
------------

// File: rtl/dassign1_code_gen_pkg.sv
// Shared encodings for the code-classifier stimulus generator:
// mode selects, set lengths, FSM states and the accepted-set predicate.
package dassign1_code_gen_pkg;

    localparam logic [1:0] MODE_ACC = 2'b00;
    localparam logic [1:0] MODE_REJ = 2'b01;
    localparam logic [1:0] MODE_ALL = 2'b10;

    localparam logic [4:0] LEN_ACC = 5'd6;
    localparam logic [4:0] LEN_REJ = 5'd10;
    localparam logic [4:0] LEN_ALL = 5'd16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_accepted(input logic [3:0] c);
        return c inside {4'd3, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11};
    endfunction

endpackage

// File: rtl/dassign1_code_rom.sv
// Combinational set table: (mode, index) -> code, its expected class and the set length.
module dassign1_code_rom
    import dassign1_code_gen_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [3:0] index,
    output logic [3:0] code,
    output logic       code_exp,
    output logic [4:0] set_len
);

    always_comb begin
        code    = index;
        set_len = LEN_ALL;
        case (mode)
            MODE_ACC: begin
                set_len = LEN_ACC;
                case (index)
                    4'd0:    code = 4'd3;
                    4'd1:    code = 4'd6;
                    4'd2:    code = 4'd7;
                    4'd3:    code = 4'd9;
                    4'd4:    code = 4'd10;
                    default: code = 4'd11;
                endcase
            end
            MODE_REJ: begin
                set_len = LEN_REJ;
                case (index)
                    4'd0:    code = 4'd0;
                    4'd1:    code = 4'd1;
                    4'd2:    code = 4'd2;
                    4'd3:    code = 4'd4;
                    4'd4:    code = 4'd5;
                    4'd5:    code = 4'd8;
                    4'd6:    code = 4'd12;
                    4'd7:    code = 4'd13;
                    4'd8:    code = 4'd14;
                    default: code = 4'd15;
                endcase
            end
            // 2'b11 falls through to the full ascending sweep
            default: begin
                set_len = LEN_ALL;
                code    = index;
            end
        endcase
        code_exp = is_accepted(code);
    end

endmodule

// File: rtl/dassign1_code_gen.sv
// Stimulus transmitter: streams 4-bit codes with expected classifier output over valid/ready.
// All outputs are registered; the ROM is addressed with the next index so the new code lands with the handshake.
module dassign1_code_gen
    import dassign1_code_gen_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             code_valid,
    input  logic             code_ready,
    output logic [3:0]       code,
    output logic             code_exp,
    output logic             code_last,
    output logic             done
);

    // Wide enough for both the count field and a full-pass length of 16
    localparam int REM_W = (CNT_W > 5) ? CNT_W : 5;

    state_t           state;
    logic [1:0]       mode_q;
    logic [3:0]       index;
    logic [4:0]       setlen_q;
    logic [REM_W-1:0] remaining;

    logic [3:0]       idx_next;
    logic [1:0]       rom_mode;
    logic [3:0]       rom_index;
    logic [3:0]       rom_code;
    logic             rom_exp;
    logic [4:0]       rom_len;
    logic [REM_W-1:0] eff_len;
    logic             handshake;

    assign handshake = code_valid & code_ready;

    always_comb begin
        idx_next  = (({1'b0, index} + 5'd1) == setlen_q) ? 4'd0 : index + 4'd1;
        rom_mode  = (state == IDLE) ? mode : mode_q;
        rom_index = (state == IDLE) ? 4'd0 : idx_next;
        eff_len   = (count == '0) ? REM_W'(rom_len) : REM_W'(count);
    end

    dassign1_code_rom u_rom (
        .mode     (rom_mode),
        .index    (rom_index),
        .code     (rom_code),
        .code_exp (rom_exp),
        .set_len  (rom_len)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode_q     <= MODE_ACC;
            index      <= 4'd0;
            setlen_q   <= 5'd0;
            remaining  <= '0;
            busy       <= 1'b0;
            code_valid <= 1'b0;
            code       <= 4'd0;
            code_exp   <= 1'b0;
            code_last  <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        mode_q     <= mode;
                        index      <= 4'd0;
                        setlen_q   <= rom_len;
                        remaining  <= eff_len;
                        busy       <= 1'b1;
                        code_valid <= 1'b1;
                        code       <= rom_code;
                        code_exp   <= rom_exp;
                        code_last  <= (eff_len == REM_W'(1));
                    end
                end
                RUN: begin
                    if (handshake) begin
                        if (code_last) begin
                            state      <= DONE;
                            remaining  <= '0;
                            busy       <= 1'b0;
                            code_valid <= 1'b0;
                            code_last  <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            index      <= idx_next;
                            remaining  <= remaining - REM_W'(1);
                            code       <= rom_code;
                            code_exp   <= rom_exp;
                            code_last  <= (remaining == REM_W'(2));
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dassign1_code_gen.sv
// Bench for dassign1_code_gen: a queue model of the expected stream built from set membership,
// a per-cycle compare process, and directed runs covering each mode, backpressure, ignored starts and reset.
module tb_dassign1_code_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] mode;
    logic [4:0] count;
    logic       code_ready;
    logic       busy;
    logic       code_valid;
    logic [3:0] code;
    logic       code_exp;
    logic       code_last;
    logic       done;

    int n_chk = 0;
    int n_fail = 0;
    int exp_q[$];
    int set_q[$];
    bit exp_done_next = 0;
    int done_cnt = 0;
    int pops = 0;
    int last_code = -1;
    int rdy_mode = 0;
    int bp_cyc = 0;

    dassign1_code_gen #(.CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .count      (count),
        .busy       (busy),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code       (code),
        .code_exp   (code_exp),
        .code_last  (code_last),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit acc_f(input int v);
        return (v == 3) || (v == 6) || (v == 7) || (v == 9) || (v == 10) || (v == 11);
    endfunction

    task automatic build_set(input int m);
        set_q.delete();
        for (int v = 0; v < 16; v++) begin
            if ((m == 0 && acc_f(v)) || (m == 1 && !acc_f(v)) || m >= 2)
                set_q.push_back(v);
        end
    endtask

    task automatic load_model(input int m, input int c);
        int eff;
        build_set(m);
        eff = (c == 0) ? set_q.size() : c;
        for (int i = 0; i < eff; i++)
            exp_q.push_back(set_q[i % set_q.size()]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rdy_mode == 1 && code_valid) begin
            bp_cyc++;
            code_ready = (bp_cyc > 4) && (bp_cyc % 2 == 1);
            if (bp_cyc == 2) chk("stall_code", int'(code), 3);
        end
    endtask

    task automatic do_start(input int m, input int c);
        int mv;
        int cv;
        mv = m;
        cv = c;
        start = 1'b1;
        mode  = mv[1:0];
        count = cv[4:0];
        step();
        start = 1'b0;
        mode  = 2'b01;
        count = 5'd7;
        load_model(m, c);
    endtask

    task automatic wait_done(input int bound, input int exp_last, input string nm);
        int d0;
        int i;
        d0 = done_cnt;
        i = 0;
        while (done_cnt == d0 && i < bound) begin
            step();
            i++;
        end
        chk({nm, "_done_seen"}, int'(done_cnt > d0), 1);
        chk({nm, "_last_code"}, last_code, exp_last);
        chk({nm, "_drained"}, exp_q.size(), 0);
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (exp_done_next) begin
                    chk("done_pulse", int'(done), 1);
                    chk("done_busy", int'(busy), 0);
                    chk("done_valid", int'(code_valid), 0);
                    done_cnt++;
                    exp_done_next = 0;
                end else begin
                    chk("done_quiet", int'(done), 0);
                    chk("valid", int'(code_valid), int'(exp_q.size() > 0));
                    chk("busy", int'(busy), int'(exp_q.size() > 0));
                    if (code_valid && exp_q.size() > 0) begin
                        chk("code", int'(code), exp_q[0]);
                        chk("code_exp", int'(code_exp), int'(acc_f(exp_q[0])));
                        chk("code_last", int'(code_last), int'(exp_q.size() == 1));
                        if (code_ready) begin
                            last_code = int'(code);
                            pops++;
                            void'(exp_q.pop_front());
                            if (exp_q.size() == 0) exp_done_next = 1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int d0;
        int i;
        rst_n = 1'b0;
        start = 1'b0;
        mode = 2'b00;
        count = 5'd0;
        code_ready = 1'b1;

        // Pin the model's set tables to hand-written values
        build_set(0);
        chk("model_acc_len", set_q.size(), 6);
        chk("model_acc_last", set_q[5], 11);
        build_set(1);
        chk("model_rej_len", set_q.size(), 10);
        chk("model_rej_6th", set_q[5], 8);

        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(code_valid), 0);
        chk("rst_code", int'(code), 0);
        chk("rst_exp", int'(code_exp), 0);
        chk("rst_last", int'(code_last), 0);
        chk("rst_done", int'(done), 0);
        #20;
        rst_n = 1'b1;
        step();

        do_start(0, 0);
        wait_done(40, 11, "acc");
        do_start(1, 0);
        wait_done(40, 15, "rej");
        do_start(2, 18);
        wait_done(60, 1, "sweep");

        code_ready = 1'b0;
        rdy_mode = 1;
        bp_cyc = 0;
        do_start(0, 3);
        wait_done(40, 7, "bp");
        rdy_mode = 0;
        code_ready = 1'b1;

        // Starts during RUN and during the done cycle must be ignored
        do_start(0, 0);
        step();
        start = 1'b1; mode = 2'b01; count = 5'd2;
        step();
        start = 1'b0;
        i = 0;
        while (!done && i < 40) begin
            step();
            i++;
        end
        chk("ign_done_visible", int'(done), 1);
        chk("ign_last_code", last_code, 11);
        start = 1'b1; mode = 2'b11; count = 5'd1;
        step();
        start = 1'b0;
        do_start(2, 2);
        wait_done(40, 1, "after_done");

        // Asynchronous reset in the middle of a run
        do_start(2, 0);
        p0 = pops;
        i = 0;
        while (pops < p0 + 2 && i < 40) begin
            step();
            i++;
        end
        chk("mid_pops", pops - p0, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_valid", int'(code_valid), 0);
        chk("mid_rst_code", int'(code), 0);
        chk("mid_rst_exp", int'(code_exp), 0);
        chk("mid_rst_last", int'(code_last), 0);
        chk("mid_rst_done", int'(done), 0);
        exp_q.delete();
        exp_done_next = 0;
        d0 = done_cnt;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("mid_no_done", done_cnt, d0);
        do_start(2, 3);
        wait_done(40, 2, "post_rst");
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
